// File: rtl/wts_key_sequencer_pkg.sv
// Shared encodings for the WTS channel key sequencer: states, register map,
// control bits and pending-command codes.
package wts_key_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GATE    = 2'd1,
      ST_RELEASE = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      CMD_NONE    = 2'd0,
      CMD_ON      = 2'd1,
      CMD_RELEASE = 2'd2,
      CMD_OFF     = 2'd3
   } cmd_e;

   localparam logic [2:0] ADDR_GATE_LO = 3'd0;
   localparam logic [2:0] ADDR_GATE_HI = 3'd1;
   localparam logic [2:0] ADDR_REL_LO  = 3'd2;
   localparam logic [2:0] ADDR_REL_HI  = 3'd3;
   localparam logic [2:0] ADDR_CTRL    = 3'd4;

   localparam int unsigned CTRL_ON_BIT     = 0;
   localparam int unsigned CTRL_REL_BIT    = 1;
   localparam int unsigned CTRL_OFF_BIT    = 2;
   localparam int unsigned CTRL_REPEAT_BIT = 4;

   // key_off outranks key_on, which outranks key_release
   function automatic cmd_e decode_ctrl(input logic [7:0] d);
      cmd_e c;
      if (d[CTRL_OFF_BIT])      c = CMD_OFF;
      else if (d[CTRL_ON_BIT])  c = CMD_ON;
      else if (d[CTRL_REL_BIT]) c = CMD_RELEASE;
      else                      c = CMD_NONE;
      return c;
   endfunction

endpackage

// File: rtl/wts_key_sequencer_tick.sv
// wts_tick_prescaler: counts active cycles and fires tick on every TICK_DIV-th;
// clear restarts the count from zero.
module wts_tick_prescaler #(
   parameter int unsigned TICK_DIV = 256
) (
   input  logic clk,
   input  logic nreset,
   input  logic active,
   input  logic clear,
   output logic tick
);

   localparam logic [7:0] LAST = 8'(TICK_DIV - 1);

   logic [7:0] cnt_q, cnt_d;

   assign tick = active && (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (active) begin
         if (clear || tick) cnt_d = '0;
         else               cnt_d = cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/wts_key_sequencer.sv
// WTS channel key sequencer: CPU commands plus gate/release timers produce
// key pulses for the ADSR. Optional auto-repeat: `define WTS_KEY_SEQ_REPEAT_EN.
module wts_key_sequencer
   import wts_key_sequencer_pkg::*;
#(
   parameter int unsigned TICK_DIV = 256
) (
   input  logic       clk,
   input  logic       nreset,
   input  logic       active,
   input  logic       wr,
   input  logic [2:0] address,
   input  logic [7:0] wdata,
   output logic       key_on,
   output logic       key_release,
   output logic       key_off,
   output logic [1:0] state,
   output logic       busy
);

   state_e      state_q, state_d;
   cmd_e        cmd_q, cmd_d;
   logic [15:0] gate_len_q, rel_len_q;
   logic [15:0] gate_cnt_q, gate_cnt_d, rel_cnt_q, rel_cnt_d;
   logic        on_q, on_d, rel_q, rel_d, off_q, off_d;
   logic        tick, presc_clr;
   logic        ev_on, ev_rel, ev_off;
   logic        ctrl_wr;
   cmd_e        wr_cmd;
`ifdef WTS_KEY_SEQ_REPEAT_EN
   logic        repeat_q;
`endif

   wts_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
      .clk    (clk),
      .nreset (nreset),
      .active (active),
      .clear  (presc_clr),
      .tick   (tick)
   );

   assign ctrl_wr = wr && (address == ADDR_CTRL);
   assign wr_cmd  = decode_ctrl(wdata);

   // a new command written on the consuming clk replaces the one being consumed
   always_comb begin
      cmd_d = cmd_q;
      if (ctrl_wr && (wr_cmd != CMD_NONE)) cmd_d = wr_cmd;
      else if (active)                     cmd_d = CMD_NONE;
   end

   always_comb begin
      state_d    = state_q;
      gate_cnt_d = gate_cnt_q;
      rel_cnt_d  = rel_cnt_q;
      presc_clr  = 1'b0;
      ev_on      = 1'b0;
      ev_rel     = 1'b0;
      ev_off     = 1'b0;
      if (active) begin
         if (cmd_q != CMD_NONE) begin
            case (cmd_q)
               CMD_OFF: begin
                  state_d = ST_IDLE;
                  ev_off  = 1'b1;
               end
               CMD_ON: begin
                  state_d    = ST_GATE;
                  gate_cnt_d = gate_len_q;
                  presc_clr  = 1'b1;
                  ev_on      = 1'b1;
               end
               CMD_RELEASE: begin
                  if (state_q == ST_GATE) begin
                     state_d   = ST_RELEASE;
                     rel_cnt_d = rel_len_q;
                     ev_rel    = 1'b1;
                  end
               end
               default: ;
            endcase
         end else if (tick) begin
            case (state_q)
               ST_GATE: begin
                  if (gate_cnt_q == 16'd1) begin
                     state_d   = ST_RELEASE;
                     rel_cnt_d = rel_len_q;
                     ev_rel    = 1'b1;
                  end else if (gate_cnt_q != 16'd0) begin
                     gate_cnt_d = gate_cnt_q - 16'd1;
                  end
               end
               ST_RELEASE: begin
                  if (rel_cnt_q == 16'd1) begin
`ifdef WTS_KEY_SEQ_REPEAT_EN
                     if (repeat_q) begin
                        state_d    = ST_GATE;
                        gate_cnt_d = gate_len_q;
                        presc_clr  = 1'b1;
                        ev_on      = 1'b1;
                     end else begin
                        state_d = ST_IDLE;
                        ev_off  = 1'b1;
                     end
`else
                     state_d = ST_IDLE;
                     ev_off  = 1'b1;
`endif
                  end else if (rel_cnt_q == 16'd0) begin
                     state_d = ST_IDLE;
                  end else begin
                     rel_cnt_d = rel_cnt_q - 16'd1;
                  end
               end
               ST_IDLE: ;
               default: state_d = ST_IDLE;
            endcase
         end
      end
   end

   // pulses are refreshed each active cycle, so each lasts exactly one active period
   always_comb begin
      on_d  = on_q;
      rel_d = rel_q;
      off_d = off_q;
      if (active) begin
         on_d  = ev_on;
         rel_d = ev_rel;
         off_d = ev_off;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q    <= ST_IDLE;
         cmd_q      <= CMD_NONE;
         gate_len_q <= '0;
         rel_len_q  <= '0;
         gate_cnt_q <= '0;
         rel_cnt_q  <= '0;
         on_q       <= 1'b0;
         rel_q      <= 1'b0;
         off_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         gate_cnt_q <= gate_cnt_d;
         rel_cnt_q  <= rel_cnt_d;
         on_q       <= on_d;
         rel_q      <= rel_d;
         off_q      <= off_d;
         if (wr) begin
            case (address)
               ADDR_GATE_LO: gate_len_q[7:0]  <= wdata;
               ADDR_GATE_HI: gate_len_q[15:8] <= wdata;
               ADDR_REL_LO:  rel_len_q[7:0]   <= wdata;
               ADDR_REL_HI:  rel_len_q[15:8]  <= wdata;
               default: ;
            endcase
         end
      end
   end

`ifdef WTS_KEY_SEQ_REPEAT_EN
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset)      repeat_q <= 1'b0;
      else if (ctrl_wr) repeat_q <= wdata[CTRL_REPEAT_BIT];
   end
`endif

   assign key_on      = on_q;
   assign key_release = rel_q;
   assign key_off     = off_q;
   assign state       = state_q;
   assign busy        = (state_q != ST_IDLE) || (cmd_q != CMD_NONE);

endmodule
